// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the committed-store buffer.
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;

  // One pending store: word address, lane-aligned data, byte write enables.
  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  wen;
  } SBEntry;

  // Overlay the enabled byte lanes of newData onto oldData.
  function automatic logic [31:0] mergeBytes(input logic [31:0] oldData,
                                             input logic [31:0] newData,
                                             input logic [3:0]  wen);
    logic [31:0] merged;
    merged = oldData;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) merged[8*i +: 8] = newData[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store-buffer bundle: enqueue from EXE, load probe, D-cache drain, status.
// master = pipeline/cache side, slave = the buffer itself.
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             enq_valid;
  logic [31:0]      enq_addr;
  logic [31:0]      enq_data;
  logic [3:0]       enq_wen;
  logic             enq_ready;

  logic             ld_valid;
  logic [31:0]      ld_addr;
  logic             ld_conflict;

  logic             dc_req;
  logic [31:0]      dc_addr;
  logic [31:0]      dc_wdata;
  logic [3:0]       dc_wstrb;
  logic             dc_ack;

  logic             sb_empty;
  logic [CNT_W-1:0] sb_count;

  modport master (
    output enq_valid, enq_addr, enq_data, enq_wen, ld_valid, ld_addr, dc_ack,
    input  enq_ready, ld_conflict, dc_req, dc_addr, dc_wdata, dc_wstrb,
           sb_empty, sb_count
  );

  modport slave (
    input  enq_valid, enq_addr, enq_data, enq_wen, ld_valid, ld_addr, dc_ack,
    output enq_ready, ld_conflict, dc_req, dc_addr, dc_wdata, dc_wstrb,
           sb_empty, sb_count
  );

endinterface

// File: rtl/store_buffer.sv
// Committed-store buffer: circular FIFO of stores draining to the D-cache,
// merging back-to-back stores to the same word and flagging load hits.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic           clk,
  input  logic           resetn,
  store_buffer_if.slave  sb
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Register array rather than RAM: every entry is read in parallel by the load probe.
  SBEntry           entries [DEPTH];
  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic [PTR_W-1:0] newestPtr;
  logic [CNT_W-1:0] count;

  SBEntry           headEntry;
  SBEntry           newestEntry;
  logic             dcReq;
  logic             deqFire;
  logic             mergeOk;
  logic             enqReady;
  logic             enqFire;
  logic             doMerge;
  logic             doPush;
  logic             ldHit;
  logic [PTR_W-1:0] relIdx;
  logic [3:0]       unusedAddrBits;

  assign unusedAddrBits = {sb.enq_addr[1:0], sb.ld_addr[1:0]};

  // Enqueue / merge / dequeue decisions from registered state and current inputs.
  always_comb begin
    newestPtr   = tailPtr - PTR_W'(1);
    headEntry   = entries[headPtr];
    newestEntry = entries[newestPtr];
    dcReq       = (count != '0);
    deqFire     = dcReq && sb.dc_ack;
    // The in-flight head is never touched; with one entry it is the head.
    mergeOk     = ((count >= CNT_W'(2)) || ((count == CNT_W'(1)) && !dcReq))
                  && (newestEntry.waddr == sb.enq_addr[31:2])
                  && !(deqFire && (newestPtr == headPtr));
    // A retire in the same cycle does not free a slot for the incoming store.
    enqReady    = (count < FULL_CNT) || mergeOk;
    enqFire     = sb.enq_valid && enqReady && (sb.enq_wen != 4'b0000);
    doMerge     = enqFire && mergeOk;
    doPush      = enqFire && !mergeOk;
  end

  // Load probe: word match against every valid registered entry.
  always_comb begin
    ldHit  = 1'b0;
    relIdx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      relIdx = PTR_W'(i) - headPtr;
      if ((CNT_W'(relIdx) < count) && (entries[i].waddr == sb.ld_addr[31:2])) begin
        ldHit = 1'b1;
      end
    end
  end

  // Output drive; head fields read as zero while the buffer is empty.
  always_comb begin
    sb.enq_ready   = enqReady;
    sb.ld_conflict = sb.ld_valid && ldHit;
    sb.dc_req      = dcReq;
    sb.dc_addr     = dcReq ? {headEntry.waddr, 2'b00} : 32'h0;
    sb.dc_wdata    = dcReq ? headEntry.data : 32'h0;
    sb.dc_wstrb    = dcReq ? headEntry.wen : 4'b0000;
    sb.sb_empty    = (count == '0);
    sb.sb_count    = count;
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      if (doPush) begin
        entries[tailPtr] <= '{waddr: sb.enq_addr[31:2], data: sb.enq_data, wen: sb.enq_wen};
        tailPtr          <= tailPtr + PTR_W'(1);
      end
      if (doMerge) begin
        entries[newestPtr].wen  <= newestEntry.wen | sb.enq_wen;
        entries[newestPtr].data <= mergeBytes(newestEntry.data, sb.enq_data, sb.enq_wen);
      end
      if (deqFire) headPtr <= headPtr + PTR_W'(1);
      case ({doPush, deqFire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
